// File: rtl/mole_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mole_round_ctrl
// Function : Whack-a-mole round sequencer: lights a pseudo-random mole, judges
//            presses against it or the interval timeout, tracks score/misses.
// Revision : 1.0 - initial release
// ============================================================================
module mole_round_ctrl #(
  parameter int         NUM_MOLES      = 4,
  parameter int         SCORE_W        = 8,
  parameter int         MAX_MISSES     = 3,
  parameter logic [7:0] LFSR_SEED      = 8'hA5,
  parameter logic [2:0] START_INTERVAL = 3'd7,
  parameter logic [2:0] MIN_INTERVAL   = 3'd2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] btn,
  input  logic                 timeout,
  output logic                 tmr_rst_n,
  output logic [2:0]           tmr_interval,
  output logic                 tmr_dir,
  output logic [NUM_MOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [2:0]           misses,
  output logic                 hit,
  output logic                 miss,
  output logic                 game_over
);

  localparam int                 c_IDX_W      = $clog2(NUM_MOLES);
  localparam logic [SCORE_W-1:0] c_SCORE_MAX  = '1;
  localparam logic [2:0]         c_MAX_MISSES = 3'(MAX_MISSES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_WAIT   = 3'd2,
    S_RESULT = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_lfsr;
  logic [7:0]           w_lfsr_nxt;
  logic [c_IDX_W-1:0]   r_prev_idx;
  logic [c_IDX_W-1:0]   w_prev_idx;
  logic [c_IDX_W-1:0]   w_cand;
  logic [c_IDX_W-1:0]   w_idx;
  logic                 r_tmr_rst_n,  w_tmr_rst_n;
  logic [2:0]           r_interval,   w_interval;
  logic [NUM_MOLES-1:0] r_mole,       w_mole;
  logic [SCORE_W-1:0]   r_score,      w_score;
  logic [SCORE_W-1:0]   w_score_inc;
  logic [2:0]           r_misses,     w_misses;
  logic [2:0]           w_misses_inc;
  logic                 r_hit,        w_hit;
  logic                 r_miss,       w_miss;
  logic                 r_game_over,  w_game_over;
  logic                 w_wrong;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // Bump a repeat of the previous mole to its neighbour (wraps naturally)
  assign w_cand = r_lfsr[c_IDX_W-1:0];
  assign w_idx  = (w_cand == r_prev_idx) ? w_cand + c_IDX_W'(1) : w_cand;

  assign w_wrong      = |(btn & ~r_mole);
  assign w_score_inc  = (r_score == c_SCORE_MAX) ? r_score : r_score + SCORE_W'(1);
  assign w_misses_inc = r_misses + 3'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_prev_idx  = r_prev_idx;
    w_tmr_rst_n = 1'b1;
    w_interval  = r_interval;
    w_mole      = r_mole;
    w_score     = r_score;
    w_misses    = r_misses;
    w_hit       = 1'b0;
    w_miss      = 1'b0;
    w_game_over = r_game_over;

    case (r_state)
      S_IDLE, S_OVER: begin
        if (start) begin
          w_state_nxt = S_ARM;
          w_tmr_rst_n = 1'b0;
          w_score     = '0;
          w_misses    = '0;
          w_interval  = START_INTERVAL;
          w_game_over = 1'b0;
        end
      end
      S_ARM: begin
        w_state_nxt = S_WAIT;
        w_prev_idx  = w_idx;
        w_mole      = NUM_MOLES'(1) << w_idx;
      end
      S_WAIT: begin
        // A stray extra bit beats a correct one; any press beats timeout
        if (w_wrong) begin
          w_miss      = 1'b1;
          w_state_nxt = S_RESULT;
          w_mole      = '0;
        end else if (btn == r_mole) begin
          w_hit       = 1'b1;
          w_state_nxt = S_RESULT;
          w_mole      = '0;
        end else if (timeout) begin
          w_miss      = 1'b1;
          w_state_nxt = S_RESULT;
          w_mole      = '0;
        end
      end
      S_RESULT: begin
        if (r_hit) begin
          w_score = w_score_inc;
          if (w_score_inc != '0 && w_score_inc[1:0] == 2'b00 && r_interval > MIN_INTERVAL)
            w_interval = r_interval - 3'd1;
        end
        if (r_miss)
          w_misses = w_misses_inc;
        if (r_miss && w_misses_inc == c_MAX_MISSES) begin
          w_state_nxt = S_OVER;
          w_game_over = 1'b1;
        end else begin
          w_state_nxt = S_ARM;
          w_tmr_rst_n = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lfsr      <= LFSR_SEED;
      r_prev_idx  <= '0;
      r_tmr_rst_n <= 1'b1;
      r_interval  <= START_INTERVAL;
      r_mole      <= '0;
      r_score     <= '0;
      r_misses    <= '0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_prev_idx  <= w_prev_idx;
      r_tmr_rst_n <= w_tmr_rst_n;
      r_interval  <= w_interval;
      r_mole      <= w_mole;
      r_score     <= w_score;
      r_misses    <= w_misses;
      r_hit       <= w_hit;
      r_miss      <= w_miss;
      r_game_over <= w_game_over;
    end
  end

  assign tmr_rst_n    = r_tmr_rst_n;
  assign tmr_interval = r_interval;
  assign tmr_dir      = 1'b0;
  assign mole         = r_mole;
  assign score        = r_score;
  assign misses       = r_misses;
  assign hit          = r_hit;
  assign miss         = r_miss;
  assign game_over    = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_mole_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mole_round_ctrl
// Function : Directed bench for mole_round_ctrl with a round-level reference
//            model compared every cycle, plus hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mole_round_ctrl;

  localparam int NUM_MOLES  = 4;
  localparam int SCORE_W    = 8;
  localparam int MAX_MISSES = 3;
  localparam int START_IV   = 7;
  localparam int MIN_IV     = 2;

  logic                 clk     = 1'b0;
  logic                 rst_n   = 1'b1;
  logic                 start   = 1'b0;
  logic                 timeout = 1'b0;
  logic [NUM_MOLES-1:0] btn     = '0;
  logic                 tmr_rst_n;
  logic [2:0]           tmr_interval;
  logic                 tmr_dir;
  logic [NUM_MOLES-1:0] mole;
  logic [SCORE_W-1:0]   score;
  logic [2:0]           misses;
  logic                 hit;
  logic                 miss;
  logic                 game_over;

  mole_round_ctrl #(
    .NUM_MOLES(NUM_MOLES), .SCORE_W(SCORE_W), .MAX_MISSES(MAX_MISSES),
    .LFSR_SEED(8'hA5), .START_INTERVAL(3'd7), .MIN_INTERVAL(3'd2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn(btn), .timeout(timeout),
    .tmr_rst_n(tmr_rst_n), .tmr_interval(tmr_interval), .tmr_dir(tmr_dir),
    .mole(mole), .score(score), .misses(misses), .hit(hit), .miss(miss),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-level reference: what the player sees from one clock to the next
  logic [7:0] m_lfsr     = 8'hA5;
  int         m_prev     = 0;
  bit         m_playing  = 0;
  bit         m_over     = 0;
  int         m_lit      = -1;
  bit         m_arm      = 0;
  int         m_res      = 0;   // 0 none, 1 hit, 2 miss
  int         m_score    = 0;
  int         m_misses   = 0;
  int         m_interval = START_IV;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic int exp_mole();
    return (m_lit >= 0) ? (1 << m_lit) : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr = 8'hA5; m_prev = 0; m_playing = 0; m_over = 0; m_lit = -1;
      m_arm = 0; m_res = 0; m_score = 0; m_misses = 0; m_interval = START_IV;
    end else begin
      automatic bit         was_arm = m_arm;
      automatic int         was_res = m_res;
      automatic int         was_lit = m_lit;
      automatic logic [7:0] lf      = m_lfsr;
      automatic int         cur     = exp_mole();
      m_lfsr = lfsr_step(lf);
      m_arm  = 0;
      m_res  = 0;
      if (was_arm) begin
        automatic int cand = int'(lf) % NUM_MOLES;
        if (cand == m_prev) cand = (cand + 1) % NUM_MOLES;
        m_prev = cand;
        m_lit  = cand;
      end else if (was_lit >= 0) begin
        if ((int'(btn) & ~cur) != 0)      m_res = 2;
        else if (int'(btn) == cur)        m_res = 1;
        else if (btn == 0 && timeout)     m_res = 2;
        if (m_res != 0) m_lit = -1;
      end else if (was_res != 0) begin
        if (was_res == 1) begin
          if (m_score < (1 << SCORE_W) - 1) m_score++;
          if (m_score % 4 == 0 && m_interval > MIN_IV) m_interval--;
        end else begin
          m_misses++;
        end
        if (m_misses == MAX_MISSES) begin
          m_over = 1; m_playing = 0;
        end else begin
          m_arm = 1;
        end
      end else if (!m_playing && start) begin
        m_playing = 1; m_over = 0; m_arm = 1;
        m_score = 0; m_misses = 0; m_interval = START_IV;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_mole",      int'(mole),         exp_mole());
    check("cmp_hit",       int'(hit),          int'(m_res == 1));
    check("cmp_miss",      int'(miss),         int'(m_res == 2));
    check("cmp_tmr_rst_n", int'(tmr_rst_n),    int'(!m_arm));
    check("cmp_interval",  int'(tmr_interval), m_interval);
    check("cmp_tmr_dir",   int'(tmr_dir),      0);
    check("cmp_score",     int'(score),        m_score);
    check("cmp_misses",    int'(misses),       m_misses);
    check("cmp_game_over", int'(game_over),    int'(m_over));
  end

  logic [NUM_MOLES-1:0] last_mole = '0;

  task automatic wait_lit(output bit ok);
    int n = 0;
    while (m_lit < 0 && n < 12) begin
      @(negedge clk); #1; n++;
    end
    ok = (m_lit >= 0);
    check("mole_lit_in_budget", int'(ok), 1);
  endtask

  // kind: 0 correct, 1 wrong, 2 timeout, 3 correct+wrong, 4 correct+timeout
  task automatic play(input int kind, input bit stray);
    bit ok;
    logic [NUM_MOLES-1:0] m;
    logic [NUM_MOLES-1:0] other;
    wait_lit(ok);
    if (!ok) return;
    m = NUM_MOLES'(exp_mole());
    other = {m[NUM_MOLES-2:0], m[NUM_MOLES-1]};
    check("mole_onehot",  int'($onehot(mole)), 1);
    check("mole_changed", int'(mole != last_mole), 1);
    last_mole = mole;
    case (kind)
      0: begin btn = m;         timeout = 1'b0; end
      1: begin btn = other;     timeout = 1'b0; end
      2: begin btn = '0;        timeout = 1'b1; end
      3: begin btn = m | other; timeout = 1'b0; end
      default: begin btn = m;   timeout = 1'b1; end
    endcase
    @(negedge clk); #1;
    btn = '0; timeout = stray;
    check("result_hit",  int'(hit),  int'(kind == 0 || kind == 4));
    check("result_miss", int'(miss), int'(kind >= 1 && kind <= 3));
    check("result_mole", int'(mole), 0);
    @(negedge clk); #1;
  endtask

  task automatic begin_game();
    @(negedge clk); #1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    check("start_arm_restart", int'(tmr_rst_n), 0);
    check("start_score",       int'(score),     0);
    check("start_misses",      int'(misses),    0);
    check("start_game_over",   int'(game_over), 0);
    check("start_interval",    int'(tmr_interval), START_IV);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("areset_mole",      int'(mole),         0);
    check("areset_score",     int'(score),        0);
    check("areset_misses",    int'(misses),       0);
    check("areset_interval",  int'(tmr_interval), START_IV);
    check("areset_tmr_rst_n", int'(tmr_rst_n),    1);
    check("areset_pulses",    int'({hit, miss, game_over}), 0);
    last_mole = '0;
    @(negedge clk); #1;
    @(negedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    check("reset_mole",     int'(mole),         0);
    check("reset_score",    int'(score),        0);
    check("reset_interval", int'(tmr_interval), 7);
    check("reset_restart",  int'(tmr_rst_n),    1);
    @(negedge clk); #1 rst_n = 1'b1;

    // Idle noise must be ignored
    for (int i = 0; i < 6; i++) begin
      btn = NUM_MOLES'(i + 1); timeout = i[0];
      @(negedge clk); #1;
    end
    btn = '0; timeout = 1'b0;
    check("idle_mole",   int'(mole),       0);
    check("idle_pulses", int'(hit | miss), 0);

    // One hit, then three misses of different flavours
    begin_game();
    play(0, 1'b0);
    check("hit_score", int'(score), 1);
    play(2, 1'b0);
    check("timeout_misses", int'(misses), 1);
    play(1, 1'b0);
    check("wrong_misses", int'(misses), 2);
    play(3, 1'b0);
    check("over_misses",    int'(misses),    3);
    check("over_game_over", int'(game_over), 1);
    check("over_mole",      int'(mole),      0);
    check("over_score",     int'(score),     1);
    for (int i = 0; i < 3; i++) begin
      btn = NUM_MOLES'(1 << i); timeout = 1'b1;
      @(negedge clk); #1;
    end
    btn = '0; timeout = 1'b0;
    check("over_hold_misses", int'(misses), 3);

    // Fresh game: interval ramp, btn-beats-timeout, stray timeouts
    begin_game();
    for (int i = 1; i <= 22; i++) begin
      play((i == 3) ? 4 : 0, (i == 5));
      check("ramp_score",    int'(score),        i);
      check("ramp_interval", int'(tmr_interval), 7 - ((i / 4 > 5) ? 5 : i / 4));
      check("ramp_restart",  int'(tmr_rst_n),    0);
      check("ramp_misses",   int'(misses),       0);
    end
    timeout = 1'b0;

    async_reset();
    begin_game();
    for (int i = 0; i < 5; i++) play(0, 1'b0);
    check("pre_reset_score", int'(score), 5);
    begin
      bit ok;
      wait_lit(ok);
    end
    async_reset();
    repeat (3) @(negedge clk);
    check("post_reset_idle", int'(mole), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
